result_ascii_tx: RTL and testbench
==================================

// Module: result_ascii_tx
// PURPOSE
//  Output stage between the matrix-result readout FSM and uart_tx.
//  - Accepts one signed 16-bit result element per valid/ready handshake.
//  - Converts it to decimal ASCII: optional '-', digits, then delimiter or end-of-line.
//  - Streams the bytes to uart_tx one at a time via a tx_start/tx_busy handshake.
// PARAMETERS
//  DATA_W    16      result width, two's complement
//  DELIM     8'h20   byte sent after each element (space)
//  EOL_CHAR  8'h0A   byte sent instead of DELIM when val_eol=1 (row end)
//  MAX_DIG   5       max decimal digits held in the buffer (enough for 32768)
// PORTS
//  sys_clk_in  in   1       system clock, 100 MHz
//  sys_rst_n   in   1       reset, synchronous, active-low
//  val_data    in   DATA_W  result element, signed
//  val_eol     in   1       1 = terminate element with EOL_CHAR
//  val_valid   in   1       element offered
//  val_ready   out  1       block idle; element accepted when val_valid & val_ready
//  tx_data     out  8       byte to uart_tx; held stable until the next tx_start
//  tx_start    out  1       1-cycle pulse; launches tx_data
//  tx_busy     in   1       uart_tx busy; rises the cycle after tx_start
//  busy        out  1       high from acceptance until the last byte's tx_busy falls
// BEHAVIOUR
//  - Reset values: val_ready=1, tx_start=0, tx_data=8'h00, busy=0, state=IDLE, digit_cnt=0.
//  - Reset mid-operation: same values on the next edge; any partial element is dropped.
//  - States: IDLE -> CONV -> SIGN -> DIGIT -> TERM -> IDLE. TX_WAIT is entered after each
//    tx_start and returns to the calling state.
//  - IDLE: val_ready=1. On val_valid, the next edge:
//    - latches neg=val_data[15] and eol=val_eol;
//    - latches mag = |val_data| as an unsigned 16-bit value (-32768 -> 32768);
//    - drops val_ready and goes to CONV.
//  - CONV: one digit per cycle:
//    - digit_buf[digit_cnt] <= mag%10; mag <= mag/10; digit_cnt++.
//    - Exit when mag/10==0 after the write, so value 0 yields a single '0'.
//    - Leading zeros are never produced.
//    - Latency is 1..5 cycles; 32768 takes 5.
//  - SIGN: if neg, send 8'h2D ('-'); else skip directly to DIGIT.
//  - DIGIT: send 8'h30+digit_buf[idx] for idx = digit_cnt-1 down to 0 (MSD first).
//  - TERM: send EOL_CHAR if eol, else DELIM. Afterwards return to IDLE with val_ready=1
//    and busy=0 on the same edge.
//  - Send rule: tx_start pulses for exactly 1 cycle and only when tx_busy==0.
//    - TX_WAIT ignores tx_busy on the cycle after the pulse.
//    - It then waits for tx_busy==0 before moving on.
//    - Never two tx_start pulses without an intervening busy period.
//  - val_valid while val_ready=0 is ignored; the upstream block must hold the element.
//  - No element is ever accepted while a transmission is in progress.
//  - Byte count per element: neg + digit_cnt + 1. Maximum is 7 bytes ("-32768 ").
// CONFIGURATION
//  - RESULT_TX_HEX_EN defined: adds port fmt_hex (in, 1), sampled at acceptance.
//    - fmt_hex=1: CONV is skipped; SIGN is skipped.
//    - Sends exactly 4 uppercase hex digits of the raw two's-complement value, then DELIM/EOL_CHAR.
//    - Example: -30 -> "FFE2 ".
//    - fmt_hex=0: decimal as above.
//  - RESULT_TX_HEX_EN undefined: port absent; decimal only; no hex logic synthesized.
// TESTING
//  - Use a uart_tx model with tx_busy high for 10 cycles per byte.
//  1. val_data=0, eol=0 -> bytes 0x30,0x20 ("0 "); val_ready returns high after the 2nd busy falls.
//  2. val_data=-30 (16'hFFE2), eol=0 -> "-30 " = 2D,33,30,20; exactly 4 tx_start pulses.
//  3. val_data=32767 then -32768 with eol=1, back-to-back valid ->
//     "32767 " then "-32768\n"; the second element is accepted only after the first TERM completes.
//  4. val_valid held high with 11 while busy -> val_ready stays 0 throughout;
//     11 is accepted once; output is exactly "11 " once.
//  5. sys_rst_n=0 for 1 cycle during DIGIT of 12345 -> no tx_start afterwards;
//     val_ready=1, busy=0; a new element 7 -> "7 ".
//  6. With RESULT_TX_HEX_EN, fmt_hex=1, val_data=-30, eol=1 -> "FFE2\n".

Source files
------------

// File: rtl/result_ascii_tx.sv
// Converts one signed result element into decimal ASCII and sends it a byte at a time over the tx_start/tx_busy handshake.
// Optional RESULT_TX_HEX_EN adds fmt_hex to select 4-digit uppercase hex instead of decimal.
module result_ascii_tx #(
   parameter int         DATA_W   = 16,
   parameter logic [7:0] DELIM    = 8'h20,
   parameter logic [7:0] EOL_CHAR = 8'h0A,
   parameter int         MAX_DIG  = 5
) (
   input  logic              sys_clk_in,
   input  logic              sys_rst_n,
   input  logic [DATA_W-1:0] val_data,
   input  logic              val_eol,
   input  logic              val_valid,
`ifdef RESULT_TX_HEX_EN
   input  logic              fmt_hex,
`endif
   output logic              val_ready,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, TERM, TX_WAIT} state_t;

   localparam int CW = $clog2(MAX_DIG + 1);
   localparam logic [DATA_W-1:0] TEN = DATA_W'(10);

   state_t            state, state_nxt;
   state_t            ret_q, ret_nxt;
   logic              neg_q, neg_nxt;
   logic              eol_q, eol_nxt;
   logic [DATA_W-1:0] mag_q, mag_nxt;
   logic [3:0]        dbuf_q   [MAX_DIG];
   logic [3:0]        dbuf_nxt [MAX_DIG];
   logic [CW-1:0]     cnt_q, cnt_nxt;
   logic [CW-1:0]     idx_q, idx_nxt;
   logic [7:0]        tx_data_nxt;
   logic              tx_start_nxt;

   function automatic logic [7:0] to_ascii(input logic [3:0] d);
`ifdef RESULT_TX_HEX_EN
      if (d > 4'd9) return 8'h37 + {4'h0, d};
`endif
      return 8'h30 + {4'h0, d};
   endfunction

   assign val_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge sys_clk_in) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         ret_q    <= IDLE;
         neg_q    <= 1'b0;
         eol_q    <= 1'b0;
         mag_q    <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         for (int i = 0; i < MAX_DIG; i++) dbuf_q[i] <= '0;
      end else begin
         state    <= state_nxt;
         ret_q    <= ret_nxt;
         neg_q    <= neg_nxt;
         eol_q    <= eol_nxt;
         mag_q    <= mag_nxt;
         cnt_q    <= cnt_nxt;
         idx_q    <= idx_nxt;
         tx_data  <= tx_data_nxt;
         tx_start <= tx_start_nxt;
         for (int i = 0; i < MAX_DIG; i++) dbuf_q[i] <= dbuf_nxt[i];
      end
   end

   always_comb begin
      state_nxt    = state;
      ret_nxt      = ret_q;
      neg_nxt      = neg_q;
      eol_nxt      = eol_q;
      mag_nxt      = mag_q;
      cnt_nxt      = cnt_q;
      idx_nxt      = idx_q;
      tx_data_nxt  = tx_data;
      tx_start_nxt = 1'b0;
      for (int i = 0; i < MAX_DIG; i++) dbuf_nxt[i] = dbuf_q[i];

      case (state)
         IDLE: begin
            if (val_valid) begin
               neg_nxt   = val_data[DATA_W-1];
               eol_nxt   = val_eol;
               // unsigned magnitude: -32768 maps to 32768 without overflow
               mag_nxt   = val_data[DATA_W-1] ? (~val_data + 1'b1) : val_data;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = CONV;
`ifdef RESULT_TX_HEX_EN
               if (fmt_hex) begin
                  neg_nxt = 1'b0;
                  for (int i = 0; i < 4; i++) dbuf_nxt[i] = val_data[4*i +: 4];
                  cnt_nxt   = CW'(4);
                  idx_nxt   = CW'(3);
                  state_nxt = DIGIT;
               end
`endif
            end
         end
         CONV: begin
            dbuf_nxt[cnt_q] = 4'(mag_q % TEN);
            mag_nxt         = mag_q / TEN;
            cnt_nxt         = cnt_q + CW'(1);
            if (mag_nxt == '0) begin
               idx_nxt   = cnt_q;
               state_nxt = SIGN;
            end
         end
         SIGN: begin
            if (!neg_q) begin
               state_nxt = DIGIT;
            end else if (!tx_busy) begin
               tx_data_nxt  = 8'h2D;
               tx_start_nxt = 1'b1;
               ret_nxt      = DIGIT;
               state_nxt    = TX_WAIT;
            end
         end
         DIGIT: begin
            if (!tx_busy) begin
               tx_data_nxt  = to_ascii(dbuf_q[idx_q]);
               tx_start_nxt = 1'b1;
               state_nxt    = TX_WAIT;
               if (idx_q == '0) begin
                  ret_nxt = TERM;
               end else begin
                  ret_nxt = DIGIT;
                  idx_nxt = idx_q - CW'(1);
               end
            end
         end
         TERM: begin
            if (!tx_busy) begin
               tx_data_nxt  = eol_q ? EOL_CHAR : DELIM;
               tx_start_nxt = 1'b1;
               ret_nxt      = IDLE;
               state_nxt    = TX_WAIT;
            end
         end
         TX_WAIT: begin
            // tx_busy is not yet valid while our own pulse is on the wire
            if (!tx_start && !tx_busy) state_nxt = ret_q;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Scoreboarded bench for result_ascii_tx with a 10-cycle uart_tx busy model.
module tb_result_ascii_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] val_data = '0;
   logic        val_eol = 1'b0;
   logic        val_valid = 1'b0;
   logic        fmt_hex = 1'b0;
   logic        val_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          start_cnt = 0;
   int          ucnt = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   result_ascii_tx dut (
      .sys_clk_in(clk),
      .sys_rst_n (rst_n),
      .val_data  (val_data),
      .val_eol   (val_eol),
      .val_valid (val_valid),
`ifdef RESULT_TX_HEX_EN
      .fmt_hex   (fmt_hex),
`endif
      .val_ready (val_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .busy      (busy)
   );

   // uart_tx model: busy for 10 cycles after each start
   always @(posedge clk) begin
      if (!rst_n)        ucnt <= 0;
      else if (tx_start) ucnt <= 10;
      else if (ucnt != 0) ucnt <= ucnt - 1;
   end
   assign tx_busy = (ucnt != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference text for one element, from its numeric value
   function automatic string ref_text(input logic [15:0] v, input logic eol, input logic hex);
      shortint sv;
      string   s;
      sv = v;
      if (hex) s = $sformatf("%04X", v);
      else     s = $sformatf("%0d", sv);
      return {s, eol ? "\n" : " "};
   endfunction

   // Monitor: pops expected bytes whenever the DUT launches one
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() != 0) begin
            check("ready_low_while_pending", {31'd0, val_ready}, 32'd0);
            check("busy_high_while_pending", {31'd0, busy}, 32'd1);
         end
         if (tx_start) begin
            start_cnt++;
            check("start_while_uart_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // Offer an element and hold it until accepted; valid stays high on return
   task automatic offer(input logic [15:0] v, input logic eol, input logic hex);
      string s;
      bit    ok = 0;
      @(negedge clk);
      val_data  = v;
      val_eol   = eol;
      fmt_hex   = hex;
      val_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (val_ready) begin
            check("accept_when_idle", exp_q.size(), 0);
            check("accept_uart_idle", {31'd0, tx_busy}, 32'd0);
            @(posedge clk);
            s = ref_text(v, eol, hex);
            for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
            ok = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      val_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !tx_busy) done = 1;
      end
      if (!done) check("idle_timeout", 0, 1);
   endtask

   initial begin
      int          s0;
      logic [15:0] v;
      logic        hx;

      repeat (3) @(negedge clk);
      check("rst_val_ready", {31'd0, val_ready}, 32'd1);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;

      // zero gives a single digit
      offer(16'd0, 1'b0, 1'b0);
      drop_valid();
      wait_idle();
      check("t1_ready_after", {31'd0, val_ready}, 32'd1);

      // negative value, exactly four pulses
      s0 = start_cnt;
      offer(16'hFFE2, 1'b0, 1'b0);
      drop_valid();
      wait_idle();
      check("t2_pulse_count", start_cnt - s0, 4);

      // back-to-back extremes
      offer(16'h7FFF, 1'b0, 1'b0);
      offer(16'h8000, 1'b1, 1'b0);
      drop_valid();
      wait_idle();

      // valid held during activity: 11 accepted once
      offer(16'd4321, 1'b0, 1'b0);
      s0 = start_cnt;
      offer(16'd11, 1'b0, 1'b0);
      drop_valid();
      wait_idle();
      check("t4_pulse_count", start_cnt - s0, 8);

      // reset mid-DIGIT drops the element
      s0 = start_cnt;
      offer(16'd12345, 1'b0, 1'b0);
      drop_valid();
      for (int i = 0; i < 500 && start_cnt < s0 + 2; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_ready", {31'd0, val_ready}, 32'd1);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_start", {31'd0, tx_start}, 32'd0);
      s0 = start_cnt;
      repeat (40) @(negedge clk);
      check("t5_no_start_after_reset", start_cnt - s0, 0);
      offer(16'd7, 1'b0, 1'b0);
      drop_valid();
      wait_idle();

`ifdef RESULT_TX_HEX_EN
      offer(16'hFFE2, 1'b1, 1'b1);
      drop_valid();
      wait_idle();
`endif

      // randomized elements with boundary bias
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0:       v = 16'd0;
            1:       v = 16'h7FFF;
            2:       v = 16'h8000;
            3:       v = 16'($urandom_range(0, 9));
            4:       v = 16'hFFFF;
            default: v = 16'($urandom);
         endcase
         hx = 1'b0;
`ifdef RESULT_TX_HEX_EN
         hx = 1'($urandom_range(0, 1));
`endif
         offer(v, 1'($urandom_range(0, 1)), hx);
         if ($urandom_range(0, 1) == 1) begin
            drop_valid();
            repeat ($urandom_range(0, 15)) @(negedge clk);
         end
      end
      drop_valid();
      wait_idle();
      check("final_queue_empty", exp_q.size(), 0);
      check("final_ready", {31'd0, val_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
